ex_commit_stage: RTL
====================

Name: ex_commit_stage

Overview:
- Stage directly downstream of the lane-A ALU.
- Accepts one executed instruction per cycle: ALU result plus operands, PC, IR and type.
- Resolves branch/jump outcome and registers the writeback packet behind a 2-entry skid buffer with valid/ready handshake.
- Emits a one-cycle redirect/flush to fetch, and counts committed instructions.

Parameters:
- XLEN, 32, datapath width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream packet valid
- in_ready  out  1  stage can accept this cycle
- in_type  in  3  instruction class: 000 RR_ALU, 001 RI_ALU, 100 BRANCH, 101 JUMP, 111 NOP
- in_ir  in  XLEN  instruction word; opcode in IR[31:26], rd in IR[25:21]
- in_pc  in  XLEN  instruction PC
- in_a  in  XLEN  operand A, used for branch compare
- in_b  in  XLEN  operand B, used for branch compare
- in_alu  in  XLEN  ALU result; for BRANCH/JUMP this is the target
- out_valid  out  1  writeback packet valid
- out_ready  in  1  writeback consumer ready
- out_wen  out  1  register write enable
- out_rd  out  RD_W  destination register
- out_data  out  XLEN  writeback data
- out_pc  out  XLEN  PC of packet
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  redirect target
- flush  out  1  upstream must discard its in-flight packet (same timing as redirect_valid)
- commit_cnt  out  32  count of packets handed off (out_valid & out_ready)

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_wen=0, out_rd=0, out_data=0, out_pc=0, redirect_valid=0, redirect_pc=0, flush=0, commit_cnt=0, both buffer entries invalid. in_ready=0 while rst_n=0.
- Reset mid-operation: everything is cleared immediately and buffered packets are lost.
- Accept condition: in_valid & in_ready.
- in_ready = !skid_valid & !redirect_valid; it is a register-driven signal with no combinational path from out_ready.
- Buffer: main register drives the outputs; skid register holds one extra entry.
  - Main register loads from the input when it is empty or being drained.
  - Otherwise the accepted packet goes to skid.
  - Skid moves to main when main drains.
  - Order is preserved.
  - Latency input to out_valid is 1 cycle when empty.
- Packet formation at accept:
  - RR_ALU/RI_ALU: wen=1, rd=IR[25:21], data=in_alu.
  - Other types: wen=0, data=in_alu.
  - rd=0 forces wen=0.
- NOP (111) and any undefined type: accepted and sent downstream with wen=0, so they are counted.
- Branch resolution at accept, by opcode IR[31:26]:
  - 011000 BEQ: taken if a==b.
  - 011001 BNE: taken if a!=b.
  - 011010 BLT: taken if a<b (signed).
  - 011011 BGE: taken if a>=b (signed).
  - Other opcodes under BRANCH: not taken.
- JUMP is always taken.
- Taken: the next cycle sets redirect_valid=1, flush=1, redirect_pc=in_alu for exactly one cycle. The branch packet itself still enters the buffer (wen=0).
- Redirect cycle: in_ready=0, so the younger packet presented that cycle is not accepted; the upstream drops it on flush.
- Taken branches on consecutive accepts cannot occur, because acceptance is blocked for the redirect cycle.
- out_valid held with out_ready=0: all out_* fields stay stable.
- commit_cnt: increments on out_valid & out_ready and wraps modulo 2^32.

Decomposition:
- Shared package holds:
  - opcode constants (ADD..NOP, BEQ..BGE, J) and type constants (RR_ALU, RI_ALU, BRANCH, JUMP, NOP);
  - the writeback packet struct {wen, rd, data, pc}.
- One natural sub-module, branch_resolve: combinational taken/not-taken from type, opcode, a, b.
- The skid buffer stays inline.

Test Plan:
- ADD packet with rd=3, alu=0x0000_0007, out_ready=1 -> the next cycle out_valid=1, wen=1, rd=3, data=7, and commit_cnt becomes 1 the cycle after.
- BLT with a=0xFFFF_FFFF, b=1, alu=0x40, pc=0x20 -> the next cycle redirect_valid=flush=1, redirect_pc=0x40, in_ready=0 for that cycle; the packet is output with wen=0.
- BGE with a=0xFFFF_FFFF, b=1 -> no redirect, and in_ready stays 1.
- out_ready=0 while 3 back-to-back ADDs are presented -> the first two are accepted, then in_ready=0; outputs hold the first packet. After out_ready=1, the packets drain in order in 2 cycles.
- ADDI with rd=0 -> out_wen=0, commit counted.
- Assert rst_n=0 mid-drain with 2 entries buffered -> all outputs 0 immediately and commit_cnt=0; no stale packet appears after release.

Source files
------------

// File: rtl/ex_commit_stage_pkg.sv
// Shared types and constants for the lane-A commit stage: opcodes, instruction
// classes and the writeback packet.
package ex_commit_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned CNT_W  = 32;

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_AND  = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR   = 6'b000011;
  localparam logic [OP_W-1:0] OP_XOR  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b011000;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b011001;
  localparam logic [OP_W-1:0] OP_BLT  = 6'b011010;
  localparam logic [OP_W-1:0] OP_BGE  = 6'b011011;
  localparam logic [OP_W-1:0] OP_J    = 6'b011100;
  localparam logic [OP_W-1:0] OP_NOP  = 6'b111111;

  localparam logic [TYPE_W-1:0] TY_RR_ALU = 3'b000;
  localparam logic [TYPE_W-1:0] TY_RI_ALU = 3'b001;
  localparam logic [TYPE_W-1:0] TY_BRANCH = 3'b100;
  localparam logic [TYPE_W-1:0] TY_JUMP   = 3'b101;
  localparam logic [TYPE_W-1:0] TY_NOP    = 3'b111;

  typedef struct packed {
    logic            wen;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } wb_pkt_t;

  // Only the two ALU classes write the register file.
  function automatic logic is_alu_type(input logic [TYPE_W-1:0] t);
    return (t == TY_RR_ALU) || (t == TY_RI_ALU);
  endfunction

endpackage

// File: rtl/ex_commit_stage_branch_resolve.sv
// Combinational branch/jump outcome from instruction class, opcode and operands.
module ex_commit_stage_branch_resolve
  import ex_commit_stage_pkg::*;
(
  input  logic [TYPE_W-1:0] typ_i,
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              taken_c
);

  always_comb begin
    taken_c = 1'b0;
    unique case (typ_i)
      TY_JUMP: taken_c = 1'b1;
      TY_BRANCH: begin
        unique case (opcode_i)
          OP_BEQ:  taken_c = (a_i == b_i);
          OP_BNE:  taken_c = (a_i != b_i);
          OP_BLT:  taken_c = ($signed(a_i) <  $signed(b_i));
          OP_BGE:  taken_c = ($signed(a_i) >= $signed(b_i));
          default: taken_c = 1'b0;
        endcase
      end
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_commit_stage.sv
// Lane-A commit stage: resolves branches, buffers writeback packets in a
// 2-entry skid buffer, pulses redirect/flush and counts committed packets.
module ex_commit_stage
  import ex_commit_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [XLEN-1:0]   in_ir,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [XLEN-1:0]   in_alu,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wen,
  output logic [RD_W-1:0]   out_rd,
  output logic [XLEN-1:0]   out_data,
  output logic [XLEN-1:0]   out_pc,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic [CNT_W-1:0]  commit_cnt
);

  wb_pkt_t            main_q, main_d, skid_q, skid_d, new_pkt;
  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]    redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, drain, taken_c;
  logic [RD_W-1:0]    ir_rd;
  logic               unused_ir_bits;

  assign ir_rd          = in_ir[25:21];
  assign unused_ir_bits = ^in_ir[20:0];
  assign accept         = in_valid & in_ready_q;
  assign drain          = main_valid_q & out_ready;

  ex_commit_stage_branch_resolve u_branch_resolve (
    .typ_i    (in_type),
    .opcode_i (in_ir[31:26]),
    .a_i      (in_a),
    .b_i      (in_b),
    .taken_c  (taken_c)
  );

  always_comb begin
    new_pkt.wen  = is_alu_type(in_type) && (ir_rd != '0);
    new_pkt.rd   = ir_rd;
    new_pkt.data = in_alu;
    new_pkt.pc   = in_pc;
  end

  // Skid buffer: main feeds the outputs, skid absorbs one packet while main stalls.
  always_comb begin
    main_d        = main_q;
    main_valid_d  = main_valid_q;
    skid_d        = skid_q;
    skid_valid_d  = skid_valid_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = '0;
    cnt_d         = cnt_q + CNT_W'(drain);

    if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = new_pkt;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_pkt;
      skid_valid_d = 1'b1;
    end

    if (accept && taken_c) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = in_alu;
    end

    // Registered so in_ready never depends combinationally on out_ready.
    in_ready_d = !skid_valid_d && !redir_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q        <= '0;
      main_valid_q  <= 1'b0;
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
      in_ready_q    <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      cnt_q         <= '0;
    end else begin
      main_q        <= main_d;
      main_valid_q  <= main_valid_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
      in_ready_q    <= in_ready_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = main_valid_q;
  assign out_wen        = main_q.wen;
  assign out_rd         = main_q.rd;
  assign out_data       = main_q.data;
  assign out_pc         = main_q.pc;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign flush          = redir_valid_q;
  assign commit_cnt     = cnt_q;

endmodule
